// File: rtl/reply_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : reply_scheduler_if
//  Description : Command-in / transmitter-out signal bundle for the reply
//                scheduler.
//                master : command source and transmitter side
//                         (drives cmd_valid, cmd_code, tx_busy)
//                slave  : the scheduler
//                         (drives tx_start, tx_data, cmd_full, overflow,
//                          seq_busy, msg_done)
//  Revision    : 1.0  initial release
// ============================================================================
interface reply_scheduler_if;
    logic       cmd_valid;   // one-cycle pulse, cmd_code valid
    logic [1:0] cmd_code;    // 0 start, 1 stop, 2 hitsz, 3 unknown
    logic       tx_busy;     // transmitter busy with the current byte
    logic       tx_start;    // one-cycle request to send tx_data
    logic [7:0] tx_data;     // byte to transmit
    logic       cmd_full;    // pending-command queue is full
    logic       overflow;    // sticky: a command was dropped
    logic       seq_busy;    // sequencer is not idle
    logic       msg_done;    // one-cycle pulse after the last byte completes

    modport master (
        output cmd_valid, cmd_code, tx_busy,
        input  tx_start, tx_data, cmd_full, overflow, seq_busy, msg_done
    );

    modport slave (
        input  cmd_valid, cmd_code, tx_busy,
        output tx_start, tx_data, cmd_full, overflow, seq_busy, msg_done
    );
endinterface
`default_nettype wire

// File: rtl/reply_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : reply_scheduler
//  Description : Queues recognised command codes and streams the matching
//                fixed reply string, one byte per transmitter handshake.
//  Ports       : clk  - system clock
//                rst  - asynchronous active-high reset
//                bus  - reply_scheduler_if.slave (command input, transmitter
//                       handshake, status flags)
//  Revision    : 1.0  initial release
// ============================================================================
module reply_scheduler #(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    reply_scheduler_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    // Reply ROM: byte idx of the reply for code.
    function automatic logic [7:0] rom_byte(input logic [1:0] code, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (code)
            2'd0: case (idx)                      // "RUN\r\n"
                3'd0: b = 8'h52; 3'd1: b = 8'h55; 3'd2: b = 8'h4E;
                3'd3: b = 8'h0D; 3'd4: b = 8'h0A; default: b = 8'h00;
            endcase
            2'd1: case (idx)                      // "HALT\r\n"
                3'd0: b = 8'h48; 3'd1: b = 8'h41; 3'd2: b = 8'h4C;
                3'd3: b = 8'h54; 3'd4: b = 8'h0D; 3'd5: b = 8'h0A;
                default: b = 8'h00;
            endcase
            2'd2: case (idx)                      // "HITSZ\r\n"
                3'd0: b = 8'h48; 3'd1: b = 8'h49; 3'd2: b = 8'h54;
                3'd3: b = 8'h53; 3'd4: b = 8'h5A; 3'd5: b = 8'h0D;
                3'd6: b = 8'h0A; default: b = 8'h00;
            endcase
            default: case (idx)                   // "ERR\r\n"
                3'd0: b = 8'h45; 3'd1: b = 8'h52; 3'd2: b = 8'h52;
                3'd3: b = 8'h0D; 3'd4: b = 8'h0A; default: b = 8'h00;
            endcase
        endcase
        return b;
    endfunction

    function automatic logic [2:0] last_idx(input logic [1:0] code);
        case (code)
            2'd1:    return 3'd5;
            2'd2:    return 3'd6;
            default: return 3'd4;
        endcase
    endfunction

    state_t            state_q,  state_d;
    logic [1:0]        code_q,   code_d;
    logic [2:0]        idx_q,    idx_d;
    logic [1:0]        fifo_q [FIFO_DEPTH];
    logic [1:0]        fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q,  tx_data_d;
    logic              cmd_full_q, cmd_full_d;
    logic              overflow_q, overflow_d;
    logic              seq_busy_q, seq_busy_d;
    logic              msg_done_q, msg_done_d;
    logic              push;
    logic              pop;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        idx_d      = idx_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        msg_done_d = 1'b0;

        // A push while full is dropped even if LOAD pops in the same cycle.
        push       = bus.cmd_valid && !cmd_full_q;
        pop        = (state_q == S_LOAD);
        overflow_d = overflow_q || (bus.cmd_valid && cmd_full_q);

        if (push) begin
            fifo_d[wr_ptr_q] = bus.cmd_code;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // tx_data is loaded only on the transition into SEND so it stays
        // stable for the whole byte handshake.
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                code_d     = fifo_q[rd_ptr_q];
                idx_d      = 3'd0;
                tx_data_d  = rom_byte(fifo_q[rd_ptr_q], 3'd0);
                tx_start_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (idx_q == last_idx(code_q)) begin
                        msg_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        tx_data_d  = rom_byte(code_q, idx_q + 3'd1);
                        tx_start_d = 1'b1;
                        state_d    = S_SEND;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_full_d = (count_d == C_FULL_CNT);
        seq_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            code_q     <= 2'd0;
            idx_q      <= 3'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 2'd0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            cmd_full_q <= 1'b0;
            overflow_q <= 1'b0;
            seq_busy_q <= 1'b0;
            msg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            idx_q      <= idx_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            cmd_full_q <= cmd_full_d;
            overflow_q <= overflow_d;
            seq_busy_q <= seq_busy_d;
            msg_done_q <= msg_done_d;
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.cmd_full = cmd_full_q;
    assign bus.overflow = overflow_q;
    assign bus.seq_busy = seq_busy_q;
    assign bus.msg_done = msg_done_q;

endmodule
`default_nettype wire

// File: tb/tb_reply_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_reply_scheduler
//  Description : Self-checking bench for reply_scheduler. A reference model
//                built from the reply strings and a queue of pending codes
//                predicts every output; accepted commands push their reply
//                bytes into a scoreboard that a monitor drains on tx_start.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reply_scheduler;

    localparam int DEPTH    = 4;
    localparam int BUSY_LEN = 20;
    localparam int PH_IDLE  = 0;   // nothing in progress
    localparam int PH_POP   = 1;   // next edge takes a code from the queue
    localparam int PH_XFER  = 2;   // streaming reply bytes

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reply_scheduler_if bus ();

    reply_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    string replies [4] = '{"RUN\r\n", "HALT\r\n", "HITSZ\r\n", "ERR\r\n"};

    // Reference model state
    int         pend [$];
    int         m_phase = PH_IDLE;
    int         m_stage = 0;      // 0 byte launched, 1 awaiting busy, 2 awaiting idle
    int         m_cur   = 0;
    int         m_idx   = 0;
    bit         e_start = 1'b0;
    bit         e_done  = 1'b0;
    bit         e_ovf   = 1'b0;
    logic [7:0] e_data  = 8'h00;

    // Scoreboard
    logic [7:0] sb_bytes [$];
    int         sb_lens  [$];
    int         sent_in_msg = 0;

    int total      = 0;
    int bad        = 0;
    int n_timeouts = 0;
    bit busy_stuck = 1'b0;
    bit end_req    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit acc;
        int c;
        int n;
        c   = int'(bus.cmd_code);
        acc = bus.cmd_valid && (pend.size() < DEPTH);
        if (bus.cmd_valid && !acc) e_ovf = 1'b1;
        e_start = 1'b0;
        e_done  = 1'b0;
        case (m_phase)
            PH_IDLE: if (pend.size() != 0) m_phase = PH_POP;
            PH_POP: begin
                m_cur   = pend.pop_front();
                m_idx   = 0;
                m_stage = 0;
                e_start = 1'b1;
                e_data  = 8'(replies[m_cur].getc(0));
                m_phase = PH_XFER;
            end
            default: begin
                if (m_stage == 0) m_stage = 1;
                else if (m_stage == 1) begin
                    if (bus.tx_busy) m_stage = 2;
                end else if (!bus.tx_busy) begin
                    if (m_idx == replies[m_cur].len() - 1) begin
                        e_done  = 1'b1;
                        m_phase = PH_IDLE;
                    end else begin
                        m_idx++;
                        e_start = 1'b1;
                        e_data  = 8'(replies[m_cur].getc(m_idx));
                        m_stage = 0;
                    end
                end
            end
        endcase
        if (acc) begin
            pend.push_back(c);
            n = replies[c].len();
            for (int i = 0; i < n; i++) sb_bytes.push_back(8'(replies[c].getc(i)));
            sb_lens.push_back(n);
        end
    endtask

    // Model advances on the active edge using only bench-driven inputs.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                pend.delete();
                sb_bytes.delete();
                sb_lens.delete();
                m_phase = PH_IDLE;
                m_stage = 0;
                m_idx   = 0;
                e_start = 1'b0;
                e_done  = 1'b0;
                e_ovf   = 1'b0;
                e_data  = 8'h00;
            end else begin
                model_step();
            end
        end
    end

    // Monitor: samples on the falling edge, or just after reset rises.
    initial begin
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                sent_in_msg = 0;
                #1;
                check("rst_tx_start", 32'(bus.tx_start), 0);
                check("rst_tx_data",  32'(bus.tx_data),  0);
                check("rst_cmd_full", 32'(bus.cmd_full), 0);
                check("rst_overflow", 32'(bus.overflow), 0);
                check("rst_seq_busy", 32'(bus.seq_busy), 0);
                check("rst_msg_done", 32'(bus.msg_done), 0);
            end else if (end_req) begin
                check("sb_drained", 32'(sb_bytes.size()), 0);
                check("wait_timeouts", 32'(n_timeouts), 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end else begin
                check("tx_start", 32'(bus.tx_start), 32'(e_start));
                check("tx_data",  32'(bus.tx_data),  32'(e_data));
                check("msg_done", 32'(bus.msg_done), 32'(e_done));
                check("overflow", 32'(bus.overflow), 32'(e_ovf));
                check("cmd_full", 32'(bus.cmd_full), 32'(pend.size() == DEPTH));
                check("seq_busy", 32'(bus.seq_busy), 32'(m_phase != PH_IDLE));
                if (bus.tx_start) begin
                    check("sb_byte_pending", 32'(sb_bytes.size() != 0), 1);
                    if (sb_bytes.size() != 0) begin
                        check("sb_byte", 32'(bus.tx_data), 32'(sb_bytes.pop_front()));
                        sent_in_msg++;
                    end
                end
                if (bus.msg_done) begin
                    check("sb_msg_pending", 32'(sb_lens.size() != 0), 1);
                    if (sb_lens.size() != 0) check("msg_len", 32'(sent_in_msg), 32'(sb_lens.pop_front()));
                    sent_in_msg = 0;
                end
            end
        end
    end

    // Transmitter: busy one cycle after tx_start (plus a random stall) for BUSY_LEN cycles.
    initial begin : g_tx_model
        int stall;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_stuck) bus.tx_busy = 1'b1;
            else if (bus.tx_start) begin
                stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
                repeat (1 + stall) @(negedge clk);
                bus.tx_busy = 1'b1;
                repeat (BUSY_LEN) @(negedge clk);
                bus.tx_busy = 1'b0;
            end else bus.tx_busy = 1'b0;
        end
    end

    // Called on a falling edge; returns on the next one with cmd_valid low.
    task automatic send(input int code);
        bus.cmd_valid = 1'b1;
        bus.cmd_code  = 2'(code);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (!(m_phase == PH_IDLE && pend.size() == 0) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cycles) n_timeouts++;
        idle_cycles(3);
    endtask

    initial begin : g_stimulus
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_code  = 2'd0;
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(2);

        // Single command, then two queued commands
        send(0);
        wait_idle(1000);
        send(2);
        idle_cycles(2);
        send(1);
        wait_idle(2000);

        // Five back-to-back codes from idle, then fill while transmitter is stuck
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_code  = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        idle_cycles(3);
        busy_stuck = 1'b1;
        idle_cycles(30);
        for (int i = 0; i < 4; i++) begin
            send(i);
            idle_cycles(2);
        end
        idle_cycles(10);
        busy_stuck = 1'b0;
        wait_idle(5000);

        // Reset during byte 3 of "HITSZ\r\n" with two codes queued
        send(2);
        idle_cycles(2);
        send(1);
        send(3);
        n = 0;
        while (!(m_phase == PH_XFER && m_cur == 2 && m_idx == 2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) n_timeouts++;
        @(posedge clk);
        #3;
        rst = 1'b1;
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(40);

        // Unknown code
        send(3);
        wait_idle(1000);

        // Random traffic
        for (int i = 0; i < 30; i++) begin
            send(int'($urandom_range(0, 3)));
            idle_cycles(int'($urandom_range(0, 60)));
        end
        wait_idle(20000);

        end_req = 1'b1;
        idle_cycles(5);
        $display("FAIL end_of_test: summary not reached");
        $fatal(1, "monitor did not finish");
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
